// File: rtl/ad9361_dds_tx_sched.sv
// ---------------------------------------------------------------------------
// ad9361_dds_tx_sched
//
// Multi-channel DDS scheduler for the AD9361 transmit path, in the data_clk
// domain. A rate divider produces one tick every RATE_DIV cycles. On each
// tick every active channel emits a phase word (accumulator + offset) to an
// external DDS compiler and advances its accumulator. The I/Q samples
// returned by the DDS are captured into per-channel hold registers. On the
// cycle after a tick they are presented to ad9361_phy, arithmetically
// shifted right by cfg_shift. A sticky underflow flag records any tick that
// found an active channel without a fresh sample.
//
// Ports:
//   clk            data clock (data_clk from ad9361_phy)
//   rst            asynchronous active-high reset
//   phy_mode       0 = 2R2T (all channels active), 1 = 1R1T (channel 0 only)
//   cfg_en         1 = run the divider and advance phase, 0 = hold
//   cfg_sync       single-cycle pulse: zero all accumulators and the divider
//   cfg_inc        per-channel phase increment, ch n at [n*PHASE_W +: PHASE_W]
//   cfg_offset     per-channel phase offset, added to the output phase only
//   cfg_shift      arithmetic right shift applied to outgoing samples (0..3)
//   phase_tdata    phase words to the DDS
//   phase_tvalid   per-channel phase strobe
//   dds_tdata      DDS samples; ch n: Q in upper DATA_W, I in lower DATA_W
//   dds_tvalid     per-channel sample strobe
//   dac_valid      sample strobe to ad9361_phy
//   dac_i / dac_q  I and Q samples to ad9361_phy, DATA_W per channel
//   underflow      sticky: a tick found an active channel with a stale sample
//   underflow_clr  clears underflow (a same-cycle set wins)
// ---------------------------------------------------------------------------
module ad9361_dds_tx_sched #(
    parameter int CH       = 2,
    parameter int PHASE_W  = 16,
    parameter int DATA_W   = 12,
    parameter int RATE_DIV = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     phy_mode,
    input  logic                     cfg_en,
    input  logic                     cfg_sync,
    input  logic [CH*PHASE_W-1:0]    cfg_inc,
    input  logic [CH*PHASE_W-1:0]    cfg_offset,
    input  logic [1:0]               cfg_shift,
    output logic [CH*PHASE_W-1:0]    phase_tdata,
    output logic [CH-1:0]            phase_tvalid,
    input  logic [CH*2*DATA_W-1:0]   dds_tdata,
    input  logic [CH-1:0]            dds_tvalid,
    output logic                     dac_valid,
    output logic [CH*DATA_W-1:0]     dac_i,
    output logic [CH*DATA_W-1:0]     dac_q,
    output logic                     underflow,
    input  logic                     underflow_clr
);

    localparam int               DIV_W    = $clog2(RATE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RATE_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    // Sign-extending right shift of one two's-complement sample.
    function automatic logic [DATA_W-1:0] ashr_sample(
        input logic [DATA_W-1:0] x,
        input logic [1:0]        sh
    );
        logic signed [DATA_W-1:0] xs;
        xs = $signed(x);
        return $unsigned(xs >>> sh);
    endfunction

    logic [DIV_W-1:0] div_cnt_r;
    logic             tick_s;
    logic [CH-1:0]    stale_s;
    logic             underflow_set_s;
    logic             dac_valid_r;
    logic             underflow_r;

    // A sync pulse swallows the tick that would otherwise fire this cycle.
    always_comb begin
        tick_s = 1'b0;
        if (cfg_en && !cfg_sync && (div_cnt_r == DIV_ZERO)) begin
            tick_s = 1'b1;
        end else begin
            tick_s = 1'b0;
        end
    end

    // Underflow is raised by any active channel that reaches a tick stale.
    always_comb begin
        underflow_set_s = 1'b0;
        if (tick_s && (|stale_s)) begin
            underflow_set_s = 1'b1;
        end else begin
            underflow_set_s = 1'b0;
        end
    end

    // Rate divider: free-runs while enabled, parked at zero by sync.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r <= DIV_ZERO;
        end else if (cfg_sync) begin
            div_cnt_r <= DIV_ZERO;
        end else if (cfg_en) begin
            if (div_cnt_r == DIV_LAST) begin
                div_cnt_r <= DIV_ZERO;
            end else begin
                div_cnt_r <= div_cnt_r + DIV_ONE;
            end
        end else begin
            div_cnt_r <= div_cnt_r;
        end
    end

    genvar g;
    for (g = 0; g < CH; g++) begin : g_ch
        logic                active_s;
        logic [PHASE_W-1:0]  acc_r;
        logic [PHASE_W-1:0]  phase_r;
        logic [PHASE_W-1:0]  phase_nxt_s;
        logic                pvalid_r;
        logic [2*DATA_W-1:0] hold_r;
        logic                fresh_r;
        logic [DATA_W-1:0]   dac_i_r;
        logic [DATA_W-1:0]   dac_q_r;
        logic [DATA_W-1:0]   dac_i_nxt_s;
        logic [DATA_W-1:0]   dac_q_nxt_s;

        // Channel 0 is always live; the others only in 2R2T mode.
        if (g == 0) begin : g_primary
            assign active_s = 1'b1;
        end else begin : g_secondary
            assign active_s = ~phy_mode;
        end

        // Offset is applied to the emitted phase only, never accumulated.
        assign phase_nxt_s = acc_r + cfg_offset[g*PHASE_W +: PHASE_W];

        // A sample arriving on the tick cycle counts as fresh for that tick.
        assign stale_s[g] = active_s & ~fresh_r & ~dds_tvalid[g];

        // Outgoing sample: shifted hold value when active, silence otherwise.
        always_comb begin
            dac_i_nxt_s = '0;
            dac_q_nxt_s = '0;
            if (active_s) begin
                dac_i_nxt_s = ashr_sample(hold_r[DATA_W-1:0], cfg_shift);
                dac_q_nxt_s = ashr_sample(hold_r[2*DATA_W-1:DATA_W], cfg_shift);
            end else begin
                dac_i_nxt_s = '0;
                dac_q_nxt_s = '0;
            end
        end

        // Phase accumulator; inactive channels stay frozen.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc_r <= '0;
            end else if (cfg_sync) begin
                acc_r <= '0;
            end else if (tick_s && active_s) begin
                acc_r <= acc_r + cfg_inc[g*PHASE_W +: PHASE_W];
            end else begin
                acc_r <= acc_r;
            end
        end

        // Phase word and strobe toward the DDS, one cycle after the tick.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                phase_r  <= '0;
                pvalid_r <= 1'b0;
            end else if (tick_s && active_s) begin
                phase_r  <= phase_nxt_s;
                pvalid_r <= 1'b1;
            end else begin
                phase_r  <= phase_r;
                pvalid_r <= 1'b0;
            end
        end

        // Sample capture; a new sample beats the tick's fresh-clear.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hold_r  <= '0;
                fresh_r <= 1'b0;
            end else if (dds_tvalid[g]) begin
                hold_r  <= dds_tdata[g*2*DATA_W +: 2*DATA_W];
                fresh_r <= 1'b1;
            end else if (tick_s && active_s) begin
                hold_r  <= hold_r;
                fresh_r <= 1'b0;
            end else begin
                hold_r  <= hold_r;
                fresh_r <= fresh_r;
            end
        end

        // DAC sample registers, updated only on ticks.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dac_i_r <= '0;
                dac_q_r <= '0;
            end else if (tick_s) begin
                dac_i_r <= dac_i_nxt_s;
                dac_q_r <= dac_q_nxt_s;
            end else begin
                dac_i_r <= dac_i_r;
                dac_q_r <= dac_q_r;
            end
        end

        assign phase_tdata[g*PHASE_W +: PHASE_W] = phase_r;
        assign phase_tvalid[g]                   = pvalid_r;
        assign dac_i[g*DATA_W +: DATA_W]         = dac_i_r;
        assign dac_q[g*DATA_W +: DATA_W]         = dac_q_r;
    end

    // One-cycle DAC strobe following each tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dac_valid_r <= 1'b0;
        end else begin
            dac_valid_r <= tick_s;
        end
    end

    // Sticky underflow; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow_r <= 1'b0;
        end else if (underflow_set_s) begin
            underflow_r <= 1'b1;
        end else if (underflow_clr) begin
            underflow_r <= 1'b0;
        end else begin
            underflow_r <= underflow_r;
        end
    end

    assign dac_valid = dac_valid_r;
    assign underflow = underflow_r;

endmodule

// File: doc/ad9361_dds_tx_sched.md
Name: ad9361_dds_tx_sched

Overview:
- Parametrised successor to the fixed single-increment DDS-to-DAC glue in the AD9361 datapath.
- Generates per-channel phase words for an external multi-channel DDS compiler and captures the returned I/Q samples.
- Presents the samples to ad9361_phy on the dac_valid cadence, with per-channel increment, phase offset, amplitude shift, 1R1T/2R2T mode and an underflow monitor.
- Sits between the DDS compiler and ad9361_phy, in the data_clk domain.

Parameters:
- CH, 2, number of TX channels (1..4); each channel is one I/Q pair.
- PHASE_W, 16, phase accumulator / phase word width.
- DATA_W, 12, I and Q sample width (two's complement).
- RATE_DIV, 4, clk cycles per dac_valid tick (>=2).

Ports:
- clk  in  1  data clock (data_clk from ad9361_phy).
- rst  in  1  asynchronous, active-high reset.
- phy_mode  in  1  0 = 2R2T (all CH active), 1 = 1R1T (channel 0 only active).
- cfg_en  in  1  1 = run ticks/phase advance; 0 = hold.
- cfg_sync  in  1  single-cycle pulse: zero all accumulators and the divider.
- cfg_inc  in  CH*PHASE_W  per-channel phase increment; ch n at [n*PHASE_W +: PHASE_W].
- cfg_offset  in  CH*PHASE_W  per-channel phase offset added to the output phase only.
- cfg_shift  in  2  arithmetic right-shift applied to outgoing samples (0..3).
- phase_tdata  out  CH*PHASE_W  phase words to the DDS.
- phase_tvalid  out  CH  per-channel phase strobe.
- dds_tdata  in  CH*2*DATA_W  DDS samples; ch n: Q at upper DATA_W, I at lower DATA_W.
- dds_tvalid  in  CH  per-channel sample strobe.
- dac_valid  out  1  sample strobe to ad9361_phy.
- dac_i  out  CH*DATA_W  I samples.
- dac_q  out  CH*DATA_W  Q samples.
- underflow  out  1  sticky: a tick occurred with a stale active channel.
- underflow_clr  in  1  clears underflow.

Behaviour:
- Reset (async, rst=1): all of the following go to 0 — accumulators, divider, phase_tdata, phase_tvalid, hold registers, fresh flags, dac_valid, dac_i, dac_q, underflow.
- Divider:
  - div_cnt counts 0..RATE_DIV-1 while cfg_en=1; tick = (div_cnt==0 && cfg_en).
  - cfg_en=0 freezes div_cnt and suppresses ticks.
- cfg_sync:
  - Forces div_cnt=0 and acc[n]=0 that cycle; no tick is issued that cycle.
  - The next cycle with cfg_en=1 is a tick.
  - cfg_sync has priority over tick.
- Phase path (active channels only; inactive channels keep phase_tvalid=0 and acc frozen):
  - On a tick, the next cycle drives phase_tvalid[n]=1 (one cycle) with phase_tdata[n] = acc[n]+cfg_offset[n], modulo 2^PHASE_W.
  - acc[n] <= acc[n]+cfg_inc[n], wrapping modulo 2^PHASE_W.
  - The first phase word after reset or sync is therefore the offset alone.
- Capture:
  - dds_tvalid[n]=1 loads hold[n] from dds_tdata and sets fresh[n].
  - No dependence on DDS latency, provided it is < RATE_DIV cycles.
- DAC output, registered, on the cycle after a tick:
  - dac_valid=1 for exactly one cycle.
  - dac_i[n]/dac_q[n] = hold I/Q >>> cfg_shift (sign-extended) for active n; 0 for inactive n.
  - fresh[n] is cleared for every active n.
- Underflow:
  - Set if any active n has fresh[n]=0 at the tick; the old hold value is repeated.
  - Sticky until underflow_clr; a simultaneous set and clear leaves it set.
- Simultaneous dds_tvalid[n] and tick: the tick uses the old hold[n]. The new sample is written and fresh[n] stays 1 for the next tick (the clear loses to the set). No underflow is flagged for that channel.
- phy_mode change: takes effect at the next tick. Newly deactivated channels output 0; newly activated channels start from their current acc and raise underflow once if not yet fresh.
- Latency: tick -> phase_tvalid is 1 cycle; tick -> dac_valid is 1 cycle. Sample pipeline latency is one tick period.

Test Plan:
- Reset, then cfg_en=1, CH=2, RATE_DIV=4, inc={0x0100,0x0080}, offset 0, DDS model echoing phase with 2-cycle latency.
  -> phase_tvalid every 4 cycles; ch0 phase sequence 0x0000, 0x0100, 0x0200…; ch1 phase sequence 0x0000, 0x0080, 0x0100…; dac_valid every 4 cycles; no underflow after the first tick.
- inc=0xF000 for ch0.
  -> phase sequence 0x0000, 0xF000, 0xE000 (wrap); offset 0x2000 gives a first output of 0x2000.
- hold I=0x800 (-2048), cfg_shift=2.
  -> dac_i = 0xE00 (-512); with phy_mode=1, dac_i[ch1] = dac_q[ch1] = 0 and phase_tvalid[1] never asserts.
- Suppress dds_tvalid for one tick period.
  -> underflow=1 and the previous samples are repeated; underflow_clr drops it; clear asserted together with a new underflow leaves underflow=1.
- dds_tvalid asserted on the tick cycle.
  -> the current dac_valid shows the old sample, the next dac_valid shows the new one, and no underflow is flagged.
- cfg_sync mid-run, then rst asserted asynchronously mid-period.
  -> after sync the accumulators restart and the first phase equals the offset; rst immediately zeroes every output without waiting for a clock edge.
